eq_seq_ctrl: RTL and testbench

EQ_SEQ_CTRL -- requirements
Module: eq_seq_ctrl

---
 rtl/eq_seq_ctrl_if.sv | 24 ++
 rtl/eq_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_eq_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/eq_seq_ctrl_if.sv
// Codec-side sample bus and filter-side sequencing outputs
// for the equalizer sequencer.
interface eq_seq_ctrl_if;
  logic        vld;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        frm_done;
  logic        ovr;

  modport master (
    output vld, lft_in, rght_in,
    input  sequencing, lft_out, rght_out,
    input  frm_done, ovr
  );

  modport slave (
    input  vld, lft_in, rght_in,
    output sequencing, lft_out, rght_out,
    output frm_done, ovr
  );
endinterface

// File: rtl/eq_seq_ctrl.sv
// Stereo sample queue and burst sequencer feeding the band filters.
// Optional sticky overrun flag: define EQ_SEQ_OVR_EN.
module eq_seq_ctrl #(
  parameter int TAPS = 1021,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  eq_seq_ctrl_if.slave  bus
);
  localparam int DEPTH = 2**AW;
  localparam int FW    = $clog2(TAPS + 1);
  localparam int CW    = $clog2(TAPS);

  typedef enum logic [1:0] {
    FILL, IDLE, LOAD, SEQ
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  new_ptr, old_ptr, rd_ptr;
  logic [FW-1:0]  fill;
  logic [CW-1:0]  cnt;
  logic           pend, pend_nxt;
  logic           seq_q, done_q;
  logic [15:0]    lft_q, rght_q;
  logic           last;

  logic [15:0]    mem_l [DEPTH];
  logic [15:0]    mem_r [DEPTH];

  assign last = (cnt == CW'(TAPS - 1));

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    unique case (state)
      FILL: begin
        if (bus.vld && fill == FW'(TAPS - 1))
          state_nxt = IDLE;
      end
      IDLE: begin
        // a queued request and a new strobe leave one still queued
        if (bus.vld || pend) begin
          state_nxt = LOAD;
          pend_nxt  = bus.vld && pend;
        end
      end
      LOAD: begin
        state_nxt = SEQ;
        if (bus.vld) pend_nxt = 1'b1;
      end
      SEQ: begin
        if (last) state_nxt = IDLE;
        if (bus.vld) pend_nxt = 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // queue storage survives reset
  always_ff @(posedge clk) begin
    if (bus.vld) begin
      mem_l[new_ptr] <= bus.lft_in;
      mem_r[new_ptr] <= bus.rght_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      new_ptr <= '0;
      old_ptr <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      seq_q   <= 1'b0;
      done_q  <= 1'b0;
      lft_q   <= '0;
      rght_q  <= '0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      done_q <= 1'b0;
      if (bus.vld) begin
        new_ptr <= new_ptr + 1'b1;
        if (fill != FW'(TAPS))
          fill <= fill + 1'b1;
      end
      if (state == LOAD) begin
        lft_q  <= mem_l[old_ptr];
        rght_q <= mem_r[old_ptr];
        rd_ptr <= old_ptr + 1'b1;
        cnt    <= '0;
        seq_q  <= 1'b1;
      end
      if (state == SEQ) begin
        if (last) begin
          seq_q   <= 1'b0;
          done_q  <= 1'b1;
          old_ptr <= old_ptr + 1'b1;
        end else begin
          lft_q  <= mem_l[rd_ptr];
          rght_q <= mem_r[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.sequencing = seq_q;
  assign bus.frm_done   = done_q;
  assign bus.lft_out    = lft_q;
  assign bus.rght_out   = rght_q;

`ifdef EQ_SEQ_OVR_EN
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovr_q <= 1'b0;
    else if (bus.vld && pend)
      ovr_q <= 1'b1;
  end

  assign bus.ovr = ovr_q;
`else
  assign bus.ovr = 1'b0;
`endif
endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Directed bench for eq_seq_ctrl: fill, passes, wrap,
// pend/overrun and mid-pass reset.
module tb_eq_seq_ctrl;
  localparam int TAPS  = 1021;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
`ifdef EQ_SEQ_OVR_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_seq_ctrl_if bus ();

  eq_seq_ctrl #(.TAPS(TAPS), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] m_l [DEPTH];
  logic [15:0] m_r [DEPTH];
  int wptr = 0;
  int optr = 0;
  int passes = 0;
  int serial = 0;
  int tp;
  int k = 0;
  int perr = 0;
  bit in_pass = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send();
    @(posedge clk); #1;
    bus.vld     = 1'b1;
    bus.lft_in  = serial[15:0];
    bus.rght_in = ~serial[15:0];
    m_l[wptr]   = serial[15:0];
    m_r[wptr]   = ~serial[15:0];
    wptr        = (wptr + 1) % DEPTH;
    serial++;
    @(posedge clk); #1;
    bus.vld = 1'b0;
  endtask

  task automatic wait_pass(input int target);
    for (int i = 0; i < 3000 && passes < target; i++)
      @(negedge clk);
    chk("pass_cnt", passes, target);
  endtask

  task automatic wait_frm();
    for (int i = 0; i < 3000 && bus.frm_done !== 1'b1; i++)
      @(negedge clk);
    chk("frm_seen", bus.frm_done, 1);
  endtask

  task automatic pend_start();
    @(negedge clk);
    chk("pend_load", bus.sequencing, 0);
    @(negedge clk);
    chk("pend_seq", bus.sequencing, 1);
  endtask

  // pass monitor: data, length, frm_done and output hold
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pass = 1'b0;
      k = 0;
      perr = 0;
    end else if (bus.sequencing === 1'b1) begin
      if (bus.lft_out !== m_l[(optr + k) % DEPTH] ||
          bus.rght_out !== m_r[(optr + k) % DEPTH])
        perr++;
      k++;
      in_pass = 1'b1;
    end else if (in_pass) begin
      chk("pass_len", k, TAPS);
      chk("pass_data", perr, 0);
      chk("pass_frm", bus.frm_done, 1);
      chk("hold_l", bus.lft_out, m_l[(optr + TAPS - 1) % DEPTH]);
      optr = (optr + 1) % DEPTH;
      passes++;
      in_pass = 1'b0;
      k = 0;
      perr = 0;
    end else if (bus.frm_done !== 1'b0) begin
      chk("stray_frm", bus.frm_done, 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.vld = 1'b0;
    bus.lft_in = '0;
    bus.rght_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seq", bus.sequencing, 0);
    chk("rst_frm", bus.frm_done, 0);
    chk("rst_lft", bus.lft_out, 0);
    chk("rst_rght", bus.rght_out, 0);
    chk("rst_ovr", bus.ovr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (TAPS - 1) send();
    repeat (3) @(negedge clk);
    chk("fill_seq", bus.sequencing, 0);
    send();
    repeat (4) @(negedge clk);
    chk("full_seq", bus.sequencing, 0);
    chk("full_nopass", passes, 0);

    send();
    @(negedge clk);
    chk("load_lat", bus.sequencing, 0);
    @(negedge clk);
    chk("seq_rise", bus.sequencing, 1);
    wait_pass(1);
    send();
    wait_pass(2);

    for (int p = 0; p < 6; p++) begin
      send();
      wait_pass(3 + p);
      repeat (60) @(posedge clk);
    end
    tp = passes;

    send();
    repeat (100) @(posedge clk);
    send();
    wait_frm();
    pend_start();
    tp += 2;
    wait_pass(tp);
    chk("ovr_single", bus.ovr, 0);

    send();
    repeat (100) @(posedge clk);
    send();
    send();
    wait_frm();
    pend_start();
    tp += 2;
    wait_pass(tp);
    chk("ovr_set", bus.ovr, OVR);
    repeat (1200) @(negedge clk);
    chk("no_extra", passes, tp);
    chk("ovr_sticky", bus.ovr, OVR);

    send();
    @(negedge clk);
    @(negedge clk);
    chk("end_seq", bus.sequencing, 1);
    repeat (TAPS - 2) @(posedge clk);
    send();
    @(negedge clk);
    chk("end_frm", bus.frm_done, 1);
    pend_start();
    tp += 2;
    wait_pass(tp);

    send();
    @(negedge clk);
    @(negedge clk);
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_seq", bus.sequencing, 0);
    chk("mrst_lft", bus.lft_out, 0);
    chk("mrst_rght", bus.rght_out, 0);
    chk("mrst_frm", bus.frm_done, 0);
    chk("mrst_ovr", bus.ovr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wptr = 0;
    optr = 0;
    tp = passes;
    repeat (TAPS) send();
    repeat (4) @(negedge clk);
    chk("refill_seq", bus.sequencing, 0);
    chk("refill_nopass", passes, tp);
    send();
    wait_pass(tp + 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
